multi_stream_aggregator: RTL and testbench
==========================================

MULTI_STREAM_AGGREGATOR -- requirements
Module: multi_stream_aggregator

Interface
REQ-001 Parameter NUM_CH, default 2: number of input channels, range 2-8.
REQ-002 Parameter LANE_W, default 32: input word width in bits.
REQ-003 Parameter LANES, default 8: lanes per output word; output width is LANE_W*LANES.
REQ-004 Parameter PACK, default 0: 0 = pad each record to an output word boundary; 1 = pack records back-to-back.
REQ-005 Parameter TIMEOUT, default 16: idle cycles before a partial word is flushed when PACK=1, range 1-255.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 in_data  in  NUM_CH*LANE_W  channel c word at bits [c*LANE_W +: LANE_W].
REQ-009 in_valid  in  NUM_CH  per-channel word valid.
REQ-010 in_last  in  NUM_CH  per-channel end-of-record marker, qualified by in_valid.
REQ-011 in_ready  out  NUM_CH  per-channel accept; a word transfers when in_valid[c] and in_ready[c] are both high.
REQ-012 out_data  out  LANE_W*LANES  packed word; lane k at bits [k*LANE_W +: LANE_W].
REQ-013 out_keep  out  LANES  lane-occupied mask.
REQ-014 out_last  out  1  word closes a record (PACK=0) or was flushed by timeout (PACK=1).
REQ-015 out_valid  out  1  output word valid.
REQ-016 out_ready  in  1  downstream accept.

Function
REQ-017 The FSM SHALL have states IDLE, XFER and FLUSH; a record from a granted channel is atomic and is never interleaved with another channel.
REQ-018 IDLE: if any in_valid is high, grant the first requesting channel in round-robin order starting at (last_grant+1) mod NUM_CH, and go to XFER on the next edge; after reset last_grant = NUM_CH-1.
REQ-019 XFER: in_ready[grant] = (acc_cnt < LANES); all other in_ready bits are 0; in_ready is always 0 in IDLE and FLUSH.
REQ-020 An accepted word SHALL be written to accumulator lane acc_cnt, and acc_cnt SHALL increment (range 0..LANES).
REQ-021 Transfer: when acc_cnt==LANES and (!out_valid or out_ready), the accumulator SHALL load the output register: out_keep = all ones, acc_cnt cleared.
REQ-022 Latency: out_valid SHALL rise on the 2nd rising edge after the edge that accepted the word completing the accumulator.
REQ-023 While out_valid is high and out_ready is low, out_data, out_keep and out_last SHALL hold stable.
REQ-024 PACK=0, when in_last is accepted: if acc_cnt becomes LANES, go to IDLE and send via a normal transfer with out_last=1; otherwise go to FLUSH.
REQ-025 FLUSH: transfer the partial word when (!out_valid or out_ready), with out_keep = acc_cnt low bits set, unused lanes zero, and out_last=1; then go to IDLE.
REQ-026 PACK=1: accepting in_last SHALL return the FSM to IDLE and keep the partial accumulator; the next record continues at lane acc_cnt; out_last=0 on full transfers.
REQ-027 PACK=1 timeout: an 8-bit idle counter SHALL increment in IDLE while acc_cnt>0 and in_valid==0; it clears on any grant or transfer.
REQ-028 When the idle counter reaches TIMEOUT, the FSM SHALL enter FLUSH and flush as in REQ-025 with out_last=1.
REQ-029 The grant SHALL not change while a record is open; an in_valid drop mid-record simply stalls XFER.
REQ-030 last_grant SHALL update only when a grant is issued.

Reset
REQ-031 On reset: FSM = IDLE, acc_cnt=0, accumulator and idle counter zero, last_grant=NUM_CH-1, out_valid=0, out_data=0, out_keep=0, out_last=0, in_ready=0.
REQ-032 Reset mid-record or with a pending output SHALL discard all partial and pending data, and no output word is emitted afterwards from it.

Verification
REQ-033 PACK=0, LANES=8: ch0 sends 8 words 1..8 (last on 8), out_ready=1 -> one output word, lanes 1..8, keep=0xFF, out_last=1, out_valid 2 edges after word 8.
REQ-034 PACK=0: ch1 sends 3 words, last on 3rd -> keep=0x07, lanes 3..7 zero, out_last=1, FSM returns to IDLE.
REQ-035 Both channels hold in_valid continuously with 2-word records -> grants alternate ch0, ch1, ch0, ...; no word from one record appears inside another record.
REQ-036 PACK=1, TIMEOUT=16: ch0 sends 5 words, ch1 sends 3 words -> one word with keep=0xFF and out_last=0; then ch0 sends 2 words and goes idle -> flush after 16 idle cycles, keep=0x03, out_last=1.
REQ-037 out_ready held low for 20 cycles with 16 words queued -> first word holds stable, the accumulator fills, in_ready drops, and no data is lost after out_ready rises.
REQ-038 Assert reset with acc_cnt=5 mid-record -> all outputs return to reset values on the next edge, and a following 8-word record is emitted clean.

Source files
------------

// File: rtl/multi_stream_aggregator.sv
// ============================================================================
// multi_stream_aggregator: round-robin record aggregator into wide output words
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_stream_aggregator #(
    parameter int NUM_CH  = 2,
    parameter int LANE_W  = 32,
    parameter int LANES   = 8,
    parameter int PACK    = 0,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*LANE_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [LANE_W*LANES-1:0]  out_data,
    output logic [LANES-1:0]         out_keep,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int               CNT_W       = $clog2(LANES + 1);
    localparam int               OUT_W       = LANE_W * LANES;
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(LANES);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]    NUM_CH_EXT  = (CH_W+1)'(NUM_CH);
    localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  grant_q, grant_d;
    logic [CH_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             full_q, full_d;
    logic             last_pend_q, last_pend_d;
    logic [7:0]       idle_q, idle_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [LANES-1:0] out_keep_q, out_keep_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;

    logic [LANE_W-1:0] sel_word;
    logic              sel_valid;
    logic              sel_last;

    always_comb begin
        sel_word  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q == CH_W'(c)) begin
                sel_word  = in_data[c*LANE_W +: LANE_W];
                sel_valid = in_valid[c];
                sel_last  = in_last[c];
            end
        end
    end

    // Rotate requests so bit 0 is the channel after last_grant, then pick the lowest set bit.
    logic [CH_W-1:0]   rr_start;
    logic [CH_W-1:0]   rr_off;
    logic [CH_W-1:0]   rr_pick;
    logic [CH_W:0]     rr_sum;
    logic [NUM_CH-1:0] rr_rot;
    logic              rr_found;

    always_comb begin
        rr_start = (last_grant_q == LAST_CH) ? '0 : last_grant_q + 1'b1;
        rr_rot   = NUM_CH'({in_valid, in_valid} >> rr_start);
        rr_found = 1'b0;
        rr_off   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rr_found && rr_rot[i]) begin
                rr_found = 1'b1;
                rr_off   = CH_W'(i);
            end
        end
        rr_sum  = {1'b0, rr_start} + {1'b0, rr_off};
        rr_pick = (rr_sum >= NUM_CH_EXT) ? CH_W'(rr_sum - NUM_CH_EXT) : rr_sum[CH_W-1:0];
    end

    logic             acc_open;
    logic             out_free;
    logic             accept;
    logic             full_xfer;
    logic             flush_xfer;
    logic [LANES-1:0] part_keep;
    logic [OUT_W-1:0] part_mask;

    assign acc_open   = (acc_cnt_q < FULL_CNT);
    assign out_free   = !out_valid_q || out_ready;
    assign accept     = (state_q == XFER) && acc_open && sel_valid;
    assign full_xfer  = full_q && (acc_cnt_q == FULL_CNT) && out_free;
    assign flush_xfer = (state_q == FLUSH) && out_free;

    always_comb begin
        in_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready[c] = (state_q == XFER) && acc_open && (grant_q == CH_W'(c));
        end
    end

    always_comb begin
        part_keep = '0;
        part_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            part_keep[k]                  = (CNT_W'(k) < acc_cnt_q);
            part_mask[k*LANE_W +: LANE_W] = {LANE_W{part_keep[k]}};
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        acc_cnt_d    = acc_cnt_q;
        acc_d        = acc_q;
        last_pend_d  = last_pend_q;
        idle_d       = idle_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q && !out_ready;
        // Full is seen one cycle late so a full word leaves two edges after its last lane.
        full_d       = (acc_cnt_q == FULL_CNT) && !full_xfer;

        if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                if (acc_cnt_q == CNT_W'(k)) begin
                    acc_d[k*LANE_W +: LANE_W] = sel_word;
                end
            end
            acc_cnt_d = acc_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if ((PACK != 0) && (idle_q >= TIMEOUT_CNT) && (acc_cnt_q != '0) && acc_open) begin
                    state_d = FLUSH;
                    idle_d  = '0;
                end else if (rr_found) begin
                    grant_d      = rr_pick;
                    last_grant_d = rr_pick;
                    state_d      = XFER;
                    idle_d       = '0;
                end else if ((PACK != 0) && (acc_cnt_q != '0) && (idle_q != 8'hFF)) begin
                    idle_d = idle_q + 8'd1;
                end
            end
            XFER: begin
                if (accept && sel_last) begin
                    if (PACK != 0) begin
                        state_d = IDLE;
                    end else if ((acc_cnt_q + 1'b1) == FULL_CNT) begin
                        state_d     = IDLE;
                        last_pend_d = 1'b1;
                    end else begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (full_xfer) begin
            out_data_d  = acc_q;
            out_keep_d  = '1;
            out_last_d  = (PACK == 0) && last_pend_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_cnt_d   = '0;
            last_pend_d = 1'b0;
            idle_d      = '0;
        end else if (flush_xfer) begin
            out_data_d  = acc_q & part_mask;
            out_keep_d  = part_keep;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_cnt_d   = '0;
            idle_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_CH;
            acc_cnt_q    <= '0;
            acc_q        <= '0;
            full_q       <= 1'b0;
            last_pend_q  <= 1'b0;
            idle_q       <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_q        <= acc_d;
            full_q       <= full_d;
            last_pend_q  <= last_pend_d;
            idle_q       <= idle_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_stream_aggregator.sv
// ============================================================================
// tb_multi_stream_aggregator: directed bench for PACK=0 (dut0) and PACK=1 (dut1)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multi_stream_aggregator;
    logic         clk = 1'b0;
    logic         rst0, rst1;
    logic [63:0]  in_data0, in_data1;
    logic [1:0]   in_valid0, in_valid1, in_last0, in_last1, in_ready0, in_ready1;
    logic [255:0] out_data0, out_data1;
    logic [7:0]   out_keep0, out_keep1;
    logic         out_last0, out_last1, out_valid0, out_valid1, out_ready0, out_ready1;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    multi_stream_aggregator #(.NUM_CH(2), .LANE_W(32), .LANES(8), .PACK(0), .TIMEOUT(16)) dut0 (
        .clk(clk), .reset(rst0), .in_data(in_data0), .in_valid(in_valid0), .in_last(in_last0),
        .in_ready(in_ready0), .out_data(out_data0), .out_keep(out_keep0), .out_last(out_last0),
        .out_valid(out_valid0), .out_ready(out_ready0)
    );

    multi_stream_aggregator #(.NUM_CH(2), .LANE_W(32), .LANES(8), .PACK(1), .TIMEOUT(16)) dut1 (
        .clk(clk), .reset(rst1), .in_data(in_data1), .in_valid(in_valid1), .in_last(in_last1),
        .in_ready(in_ready1), .out_data(out_data1), .out_keep(out_keep1), .out_last(out_last1),
        .out_valid(out_valid1), .out_ready(out_ready1)
    );

    function automatic logic [255:0] mkword(input logic [31:0] base, input int n);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < n) w[k*32 +: 32] = base + 32'(k);
        end
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit which, input int ch, input logic v, input logic [31:0] d, input logic l);
        if (!which) begin
            in_valid0[ch] = v;
            in_data0[ch*32 +: 32] = d;
            in_last0[ch] = l;
        end else begin
            in_valid1[ch] = v;
            in_data1[ch*32 +: 32] = d;
            in_last1[ch] = l;
        end
    endtask

    // Sends n words base..base+n-1 on one channel; returns one step after the last accepting edge.
    task automatic send(input bit which, input int ch, input int n, input logic [31:0] base, input bit with_last);
        int  guard;
        bit  done;
        for (int i = 0; i < n; i++) begin
            drive(which, ch, 1'b1, base + 32'(i), with_last && (i == n - 1));
            guard = 0;
            done  = 1'b0;
            while (!done) begin
                #1;
                done = which ? in_ready1[ch] : in_ready0[ch];
                tick;
                guard++;
                if (!done && guard > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout dut%0d ch%0d word %0d: in_ready low for %0d cycles, required high", which, ch, i, guard);
                    done = 1'b1;
                end
            end
        end
        drive(which, ch, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic wait_out(input bit which, input int bound);
        int n;
        n = 0;
        while (!(which ? out_valid1 : out_valid0) && n < bound) begin
            tick;
            n++;
        end
        checks++;
        if (!(which ? out_valid1 : out_valid0)) begin
            errors++;
            $display("FAIL wait_out dut%0d: out_valid 0 after %0d cycles, required 1", which, bound);
        end
    endtask

    task automatic test_reset;
        rst0 = 1'b1; rst1 = 1'b1;
        in_data0 = '0; in_data1 = '0;
        in_valid0 = 2'b11; in_valid1 = 2'b11;
        in_last0 = '0; in_last1 = '0;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        tick;
        tick;
        checks++;
        if ({out_valid0, out_last0, out_keep0, in_ready0} !== 12'd0) begin
            errors++;
            $display("FAIL reset_ctrl0 got valid=%b last=%b keep=%h ready=%b required all 0", out_valid0, out_last0, out_keep0, in_ready0);
        end
        checks++;
        if (out_data0 !== '0) begin
            errors++;
            $display("FAIL reset_data0 got %h required 0", out_data0);
        end
        checks++;
        if ({out_valid1, out_last1, out_keep1, in_ready1} !== 12'd0 || out_data1 !== '0) begin
            errors++;
            $display("FAIL reset_dut1 got valid=%b last=%b keep=%h ready=%b required all 0", out_valid1, out_last1, out_keep1, in_ready1);
        end
        in_valid0 = '0; in_valid1 = '0;
        rst0 = 1'b0; rst1 = 1'b0;
        tick;
        checks++;
        if (in_ready0 !== 2'b00 || out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle0 got ready=%b valid=%b required 00/0", in_ready0, out_valid0);
        end
    endtask

    task automatic test_full_record;
        send(1'b0, 0, 8, 32'd1, 1'b1);
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL full_lat0 got out_valid=%b required 0 right after last accept", out_valid0);
        end
        tick;
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL full_lat1 got out_valid=%b required 0 one edge later", out_valid0);
        end
        tick;
        checks++;
        if (out_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL full_lat2 got out_valid=%b required 1 two edges later", out_valid0);
        end
        checks++;
        if (out_data0 !== mkword(32'd1, 8) || out_keep0 !== 8'hFF || out_last0 !== 1'b1) begin
            errors++;
            $display("FAIL full_word got data=%h keep=%h last=%b required data=%h keep=ff last=1", out_data0, out_keep0, out_last0, mkword(32'd1, 8));
        end
        tick;
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL full_drop got out_valid=%b required 0 after consumption", out_valid0);
        end
    endtask

    task automatic test_partial;
        send(1'b0, 1, 3, 32'h100, 1'b1);
        wait_out(1'b0, 10);
        checks++;
        if (out_data0 !== mkword(32'h100, 3) || out_keep0 !== 8'h07 || out_last0 !== 1'b1) begin
            errors++;
            $display("FAIL partial_word got data=%h keep=%h last=%b required data=%h keep=07 last=1", out_data0, out_keep0, out_last0, mkword(32'h100, 3));
        end
        tick;
        tick;
        checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 2'b00) begin
            errors++;
            $display("FAIL partial_idle got valid=%b ready=%b required 0/00", out_valid0, in_ready0);
        end
    endtask

    task automatic test_round_robin;
        int cnt0, cnt1, nout, cyc, ch;
        bit a0, a1;
        logic [255:0] exp;
        cnt0 = 0; cnt1 = 0; nout = 0; cyc = 0;
        while (nout < 4 && cyc < 200) begin
            drive(1'b0, 0, cnt0 < 4, 32'h1000 + 32'(cnt0), (cnt0 % 2) == 1);
            drive(1'b0, 1, cnt1 < 4, 32'h2000 + 32'(cnt1), (cnt1 % 2) == 1);
            #1;
            a0 = in_valid0[0] && in_ready0[0];
            a1 = in_valid0[1] && in_ready0[1];
            if (out_valid0) begin
                ch  = nout % 2;
                exp = mkword(32'h1000 * 32'(ch + 1) + 32'(2 * (nout / 2)), 2);
                checks++;
                if (out_data0 !== exp || out_keep0 !== 8'h03 || out_last0 !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_word%0d got data=%h keep=%h last=%b required data=%h keep=03 last=1", nout, out_data0, out_keep0, out_last0, exp);
                end
                nout++;
            end
            tick;
            if (a0) cnt0++;
            if (a1) cnt1++;
            cyc++;
        end
        drive(1'b0, 0, 1'b0, 32'd0, 1'b0);
        drive(1'b0, 1, 1'b0, 32'd0, 1'b0);
        checks++;
        if (nout != 4) begin
            errors++;
            $display("FAIL rr_count got %0d words required 4", nout);
        end
    endtask

    task automatic test_pack;
        bit early;
        logic [255:0] exp;
        send(1'b1, 0, 5, 32'hA0, 1'b1);
        send(1'b1, 1, 3, 32'hB0, 1'b1);
        wait_out(1'b1, 10);
        exp = mkword(32'hA0, 5) | (mkword(32'hB0, 3) << 160);
        checks++;
        if (out_data1 !== exp || out_keep1 !== 8'hFF || out_last1 !== 1'b0) begin
            errors++;
            $display("FAIL pack_full got data=%h keep=%h last=%b required data=%h keep=ff last=0", out_data1, out_keep1, out_last1, exp);
        end
        tick;
        send(1'b1, 0, 2, 32'hC0, 1'b1);
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid1) early = 1'b1;
            tick;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL pack_early got out_valid=1 within 15 idle cycles required 0");
        end
        wait_out(1'b1, 10);
        checks++;
        if (out_data1 !== mkword(32'hC0, 2) || out_keep1 !== 8'h03 || out_last1 !== 1'b1) begin
            errors++;
            $display("FAIL pack_flush got data=%h keep=%h last=%b required data=%h keep=03 last=1", out_data1, out_keep1, out_last1, mkword(32'hC0, 2));
        end
        tick;
    endtask

    task automatic test_backpressure;
        int cnt, nout, cyc;
        bit a;
        logic [255:0] exp;
        logic [7:0]   ekeep;
        logic         elast;
        cnt = 0; nout = 0; cyc = 0;
        while (nout < 3 && cyc < 200) begin
            out_ready1 = (cyc >= 24);
            drive(1'b1, 1, cnt < 20, 32'h200 + 32'(cnt), cnt == 19);
            #1;
            a = in_valid1[1] && in_ready1[1];
            if (cyc == 23) begin
                checks++;
                if (cnt != 16 || in_ready1 !== 2'b00) begin
                    errors++;
                    $display("FAIL bp_stall got accepted=%0d ready=%b required 16/00", cnt, in_ready1);
                end
            end
            if (out_valid1 && !out_ready1) begin
                checks++;
                if (out_data1 !== mkword(32'h200, 8) || out_keep1 !== 8'hFF || out_last1 !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold cyc %0d got data=%h keep=%h last=%b required data=%h keep=ff last=0", cyc, out_data1, out_keep1, out_last1, mkword(32'h200, 8));
                end
            end
            if (out_valid1 && out_ready1) begin
                exp   = (nout < 2) ? mkword(32'h200 + 32'(8 * nout), 8) : mkword(32'h210, 4);
                ekeep = (nout < 2) ? 8'hFF : 8'h0F;
                elast = (nout == 2);
                checks++;
                if (out_data1 !== exp || out_keep1 !== ekeep || out_last1 !== elast) begin
                    errors++;
                    $display("FAIL bp_word%0d got data=%h keep=%h last=%b required data=%h keep=%h last=%b", nout, out_data1, out_keep1, out_last1, exp, ekeep, elast);
                end
                nout++;
            end
            tick;
            if (a) cnt++;
            cyc++;
        end
        drive(1'b1, 1, 1'b0, 32'd0, 1'b0);
        out_ready1 = 1'b1;
        checks++;
        if (nout != 3) begin
            errors++;
            $display("FAIL bp_count got %0d words required 3", nout);
        end
    endtask

    task automatic test_reset_mid;
        send(1'b0, 0, 5, 32'h300, 1'b0);
        rst0 = 1'b1;
        tick;
        checks++;
        if ({out_valid0, out_last0, out_keep0, in_ready0} !== 12'd0 || out_data0 !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got valid=%b last=%b keep=%h ready=%b required all 0", out_valid0, out_last0, out_keep0, in_ready0);
        end
        rst0 = 1'b0;
        tick;
        send(1'b0, 0, 8, 32'h400, 1'b1);
        wait_out(1'b0, 10);
        checks++;
        if (out_data0 !== mkword(32'h400, 8) || out_keep0 !== 8'hFF || out_last0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_word got data=%h keep=%h last=%b required data=%h keep=ff last=1", out_data0, out_keep0, out_last0, mkword(32'h400, 8));
        end
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_full_record;
        test_partial;
        test_round_robin;
        test_pack;
        test_backpressure;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
